// File: rtl/accum_pkg.sv
// Shared definitions for the nibble-serial accumulator: FSM state encoding
// and the width of the reused adder slice.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

endpackage

// File: rtl/add_slice_4.sv
// Pure combinational 4-bit adder slice; the accumulator time-multiplexes one
// instance across all nibbles of the operand.
module add_slice_4
  import accum_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  // Widen by one bit so the carry falls out of the top of the sum.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/accum_nibble_serial.sv
// Nibble-serial accumulator: each accepted operand is added into the
// accumulator one nibble per cycle (LSB first) with the carry registered
// between nibbles, then the result is offered on an output handshake.
// Optional build macro ACCUM_SAT_EN: unsigned saturation to all-ones when the
// final add carries out (flags still describe the unsaturated sum).
module accum_nibble_serial
  import accum_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB   = ACC_W / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [ACC_W-1:0] op_reg, op_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             msb_reg, msb_next;   // accumulator MSB before this add

  logic [NIB_W-1:0] acc_nib [NIB];
  logic [NIB_W-1:0] op_nib  [NIB];
  logic [NIB_W-1:0] slice_s;
  logic             slice_cout;
  logic             last_nib;

  // Split accumulator and operand into nibble lanes for the slice mux.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
    assign acc_nib[gi] = acc_reg[gi*NIB_W +: NIB_W];
    assign op_nib[gi]  = op_reg[gi*NIB_W +: NIB_W];
  end

  add_slice_4 u_slice (
    .a    (acc_nib[cnt_reg]),
    .b    (op_nib[cnt_reg]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  assign last_nib = (cnt_reg == CNT_W'(NIB - 1));

  // Handshake outputs; in_ready is held low while reset is asserted.
  assign in_ready  = rst_n && (state_reg == IDLE) && !clr;
  assign out_valid = (state_reg == DONE);
  assign out_sum   = acc_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;

  // Next-state and datapath update; clr overrides every state.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    op_next    = op_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    msb_next   = msb_reg;
    if (clr) begin
      state_next = IDLE;
      acc_next   = '0;
      carry_next = 1'b0;
      cnt_next   = '0;
      cout_next  = 1'b0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_next    = in_data;
            carry_next = in_cin;
            cnt_next   = '0;
            msb_next   = acc_reg[ACC_W-1];
            state_next = ADD;
          end
        end
        ADD: begin
          acc_next[cnt_reg*NIB_W +: NIB_W] = slice_s;
          carry_next = slice_cout;
          cnt_next   = cnt_reg + 1'b1;
          if (last_nib) begin
            cnt_next   = '0;
            state_next = DONE;
            cout_next  = slice_cout;
            ovf_next   = (msb_reg == op_reg[ACC_W-1]) &&
                         (slice_s[NIB_W-1] != op_reg[ACC_W-1]);
`ifdef ACCUM_SAT_EN
            if (slice_cout) begin
              acc_next = '1;
            end
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      op_reg    <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      msb_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      op_reg    <= op_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      msb_reg   <= msb_next;
    end
  end

endmodule

// File: tb/tb_accum_nibble_serial.sv
// Scoreboard bench for accum_nibble_serial: the stimulus side predicts each
// result with plain integer arithmetic and queues it; a monitor pops and
// compares whenever the DUT hands a result over.
module tb_accum_nibble_serial;

  localparam int ACC_W = 16;
  localparam int NIB   = ACC_W / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] in_data = '0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  always #5 clk = ~clk;

  accum_nibble_serial #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             cout;
    logic             ovf;
    int               hs_cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               passed = 0;
  int               total = 0;
  int               cyc = 0;
  int               txn = 0;
  logic [ACC_W-1:0] model_acc = '0;
  bit               rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: whole-word add of accumulator, operand and carry-in.
  function automatic exp_t model_add(input logic [ACC_W-1:0] op, input logic cin);
    exp_t           e;
    logic [ACC_W:0] full;
    full   = {1'b0, model_acc} + {1'b0, op} + {{ACC_W{1'b0}}, cin};
    e.sum  = full[ACC_W-1:0];
    e.cout = full[ACC_W];
    e.ovf  = (model_acc[ACC_W-1] == op[ACC_W-1]) && (e.sum[ACC_W-1] != op[ACC_W-1]);
    e.hs_cyc = 0;
`ifdef ACCUM_SAT_EN
    model_acc = e.cout ? {ACC_W{1'b1}} : e.sum;
`else
    model_acc = e.sum;
`endif
    return e;
  endfunction

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure driver
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: latency, stability under backpressure, result comparison
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [ACC_W-1:0] prev_sum = '0;
  logic             prev_cout = 1'b0;
  logic             prev_ovf = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) timeout("unexpected_out_valid");
        else check("latency", cyc, exp_q[0].hs_cyc + NIB + 1);
      end
      if (out_valid && prev_valid && !prev_ready) begin
        check("hold_sum", out_sum, prev_sum);
        check("hold_cout", out_cout, prev_cout);
        check("hold_ovf", out_ovf, prev_ovf);
        check("hold_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", out_sum, e.sum);
        check("cout", out_cout, e.cout);
        check("ovf", out_ovf, e.ovf);
        txn++;
        $display("txn %0d: sum=0x%04h cout=%0b ovf=%0b (expected 0x%04h %0b %0b)",
                 txn, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_sum   = out_sum;
      prev_cout  = out_cout;
      prev_ovf   = out_ovf;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [ACC_W-1:0] op, input logic cin);
    exp_t e;
    in_data  = op;
    in_cin   = cin;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model_add(op, cin);
        e.hs_cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    timeout("send_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    timeout("drain_timeout");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    timeout("wait_valid_timeout");
  endtask

  initial begin
    // Power-on reset, three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    // Basic add and carry chain
    @(posedge clk);
    #1;
    send(16'h1234, 1'b0);
    drain();
    @(negedge clk);
    check("in_ready_after_accept", in_ready, 1);
    @(posedge clk);
    #1;
    send(16'hFFFF, 1'b0);
    drain();
    @(posedge clk);
    #1;
    send(16'h0000, 1'b1);
    drain();

    // clr in IDLE together with in_valid: nothing accepted
    @(posedge clk);
    #1;
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0005;
    @(negedge clk);
    check("clr_blocks_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    model_acc = '0;
    @(negedge clk);
    check("clr_sum", out_sum, 0);
    check("clr_cout", out_cout, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);

    // Signed overflow with six cycles of backpressure
    @(posedge clk);
    #1;
    send(16'h7FFF, 1'b0);
    drain();
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(16'h0001, 1'b0);
    wait_valid();
    repeat (6) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // clr on the second ADD cycle discards the add
    @(posedge clk);
    #1;
    send(16'h0F0F, 1'b1);
    @(posedge clk);
    #1;
    clr = 1'b1;
    void'(exp_q.pop_back());
    model_acc = '0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("midclr_sum", out_sum, 0);
    check("midclr_out_valid", out_valid, 0);
    check("midclr_in_ready", in_ready, 1);

    // Asynchronous reset in the middle of an add
    @(posedge clk);
    #1;
    send(16'hABCD, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_acc = '0;
    @(negedge clk);
    check("midrst_sum", out_sum, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", in_ready, 1);

    // Unsigned carry-out from a large accumulator (saturates when enabled)
    @(posedge clk);
    #1;
    send(16'hFFF0, 1'b0);
    drain();
    @(posedge clk);
    #1;
    send(16'h0020, 1'b0);
    drain();

    // Randomized operands with random gaps and backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #1;
      send(16'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
